// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS fetch stage: special instruction words,
// fetch FSM states and the default pipeline drain length.
package mips_pkg;

  localparam logic [31:0] INSTR_NOP  = 32'h0000_0000;
  localparam logic [31:0] INSTR_HALT = 32'hFFFF_FFFF;

  localparam int DEFAULT_DRAIN_CYCLES = 4;

  typedef enum logic [1:0] {
    FETCH_RUN     = 2'd0,
    FETCH_DRAIN   = 2'd1,
    FETCH_HALTED  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: hold beats flush, flush loads a NOP bubble,
// otherwise the fetched instruction and its PC+4 are captured as valid.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        flush,
  input  logic [31:0] instr,
  input  logic [31:0] pc_plus4,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid
);

  always_ff @(posedge clk) begin
    if (reset) begin
      id_instr    <= INSTR_NOP;
      id_pc_plus4 <= 32'd0;
      id_valid    <= 1'b0;
    end else if (hold) begin
      id_instr    <= id_instr;
      id_pc_plus4 <= id_pc_plus4;
      id_valid    <= id_valid;
    end else if (flush) begin
      id_instr    <= INSTR_NOP;
      id_pc_plus4 <= 32'd0;
      id_valid    <= 1'b0;
    end else begin
      id_instr    <= instr;
      id_pc_plus4 <= pc_plus4;
      id_valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction fetch stage with IF/ID register and HALT drain sequencing.
// Define MIPS_DELAY_SLOT_EN to keep the instruction after a redirect (delay slot).
module fetch_unit
  import mips_pkg::*;
#(
  parameter int          IMEM_DEPTH   = 256,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_stall,
  input  logic        i_take_branch,
  input  logic [31:0] i_branch_target,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  output logic [31:0] o_id_instr,
  output logic [31:0] o_id_pc_plus4,
  output logic        o_id_valid,
  output logic        o_halt
);

  localparam int          AW         = $clog2(IMEM_DEPTH);
  localparam logic [7:0]  DRAIN_INIT = 8'(DRAIN_CYCLES);

  logic [31:0]  memory [IMEM_DEPTH];

  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  fetch_state_t state;
  logic [7:0]   drain_cnt;
  logic         halt;
  logic         in_range;
  logic         is_halt;
  logic         ifid_hold;
  logic         ifid_flush;
  logic         unused_bits;

  assign pc_plus4 = pc + 32'd4;
  // Addresses past the end of the array read as NOP rather than aliasing.
  assign in_range = (pc[31:AW+2] == '0);
  assign o_instr  = in_range ? memory[pc[AW+1:2]] : INSTR_NOP;
  assign is_halt  = (o_instr == INSTR_HALT);

  assign unused_bits = ^{pc[1:0], i_branch_target[1:0]};

  always_comb begin
    ifid_hold  = 1'b1;
    ifid_flush = 1'b0;
    case (state)
      FETCH_RUN: begin
        ifid_hold = i_stall;
`ifdef MIPS_DELAY_SLOT_EN
        // A HALT in the slot behind a redirect is still squashed.
        ifid_flush = i_take_branch & is_halt;
`else
        ifid_flush = i_take_branch;
`endif
      end
      FETCH_DRAIN: begin
        ifid_hold  = i_stall;
        ifid_flush = 1'b1;
      end
      default: begin
        ifid_hold  = 1'b1;
        ifid_flush = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      state     <= FETCH_RUN;
      drain_cnt <= 8'd0;
      halt      <= 1'b0;
    end else begin
      case (state)
        FETCH_RUN: begin
          if (!i_stall) begin
            if (i_take_branch) begin
              pc <= {i_branch_target[31:2], 2'b00};
            end else if (is_halt) begin
              state     <= FETCH_DRAIN;
              drain_cnt <= DRAIN_INIT;
            end else begin
              pc <= pc_plus4;
            end
          end
        end
        FETCH_DRAIN: begin
          // Count only cycles in which the downstream stages advance.
          if (!i_stall) begin
            if (drain_cnt <= 8'd1) begin
              drain_cnt <= 8'd0;
              state     <= FETCH_HALTED;
              halt      <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt - 8'd1;
            end
          end
        end
        FETCH_HALTED: begin
          halt <= 1'b1;
        end
        default: begin
          state <= FETCH_RUN;
        end
      endcase
    end
  end

  if_id_reg u_if_id (
    .clk         (clk),
    .reset       (reset),
    .hold        (ifid_hold),
    .flush       (ifid_flush),
    .instr       (o_instr),
    .pc_plus4    (pc_plus4),
    .id_instr    (o_id_instr),
    .id_pc_plus4 (o_id_pc_plus4),
    .id_valid    (o_id_valid)
  );

  assign o_pc   = pc;
  assign o_halt = halt;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, HALT drain, stalls,
// redirects (with and without MIPS_DELAY_SLOT_EN), address range and reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_stall;
  logic        i_take_branch;
  logic [31:0] i_branch_target;
  logic [31:0] o_pc;
  logic [31:0] o_instr;
  logic [31:0] o_id_instr;
  logic [31:0] o_id_pc_plus4;
  logic        o_id_valid;
  logic        o_halt;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef MIPS_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] A0 = 32'h2001_0001;
  localparam logic [31:0] A1 = 32'h2002_0002;
  localparam logic [31:0] A2 = 32'h2003_0003;
  localparam logic [31:0] A3 = 32'h2004_0004;
  localparam logic [31:0] ALT4 = 32'h2005_0005;

  fetch_unit #(
    .IMEM_DEPTH   (256),
    .RESET_PC     (32'h0000_0000),
    .DRAIN_CYCLES (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_stall         (i_stall),
    .i_take_branch   (i_take_branch),
    .i_branch_target (i_branch_target),
    .o_pc            (o_pc),
    .o_instr         (o_instr),
    .o_id_instr      (o_id_instr),
    .o_id_pc_plus4   (o_id_pc_plus4),
    .o_id_valid      (o_id_valid),
    .o_halt          (o_halt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] filler(input int i);
    return 32'h1000_0000 + 32'(i);
  endfunction

  initial begin
    reset = 1'b1;
    i_stall = 1'b0;
    i_take_branch = 1'b0;
    i_branch_target = 32'd0;
    for (int i = 0; i < 256; i++) dut.memory[i] = filler(i);
    dut.memory[0] = A0;
    dut.memory[1] = A1;
    dut.memory[2] = A2;
    dut.memory[3] = A3;
    dut.memory[4] = HALT;

    // Reset state
    step();
    reset = 1'b0;
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_valid", {31'd0, o_id_valid}, 32'd0);
    chk("rst_id_instr", o_id_instr, 32'h0);
    chk("rst_id_pc4", o_id_pc_plus4, 32'h0);
    chk("rst_halt", {31'd0, o_halt}, 32'd0);
    chk("rst_instr", o_instr, A0);

    // Sequential fetch
    step();
    chk("seq_pc4", o_pc, 32'h4);
    chk("seq_id0", o_id_instr, A0);
    chk("seq_id0_pc4", o_id_pc_plus4, 32'h4);
    chk("seq_id0_valid", {31'd0, o_id_valid}, 32'd1);
    step();
    chk("seq_pc8", o_pc, 32'h8);
    chk("seq_id1", o_id_instr, A1);
    step();
    step();
    chk("seq_pc16", o_pc, 32'h10);
    chk("seq_id3", o_id_instr, A3);
    chk("seq_instr_halt", o_instr, HALT);

    // HALT enters IF/ID, then four drain cycles
    step();
    chk("drain_id_halt", o_id_instr, HALT);
    chk("drain_pc_frozen", o_pc, 32'h10);
    chk("drain_halt0", {31'd0, o_halt}, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("drain_halt_c%0d", k), {31'd0, o_halt}, 32'd0);
      chk($sformatf("drain_valid_c%0d", k), {31'd0, o_id_valid}, 32'd0);
    end
    step();
    chk("halt_rise", {31'd0, o_halt}, 32'd1);
    chk("halt_pc", o_pc, 32'h10);
    i_take_branch = 1'b1;
    i_branch_target = 32'h80;
    step();
    step();
    i_take_branch = 1'b0;
    chk("halt_sticky", {31'd0, o_halt}, 32'd1);
    chk("halt_pc_ignores_branch", o_pc, 32'h10);

    // Reset in HALTED
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_halted_pc", o_pc, 32'h0);
    chk("rst_halted_halt", {31'd0, o_halt}, 32'd0);
    chk("rst_halted_valid", {31'd0, o_id_valid}, 32'd0);

    // Stall at PC=0x8
    step();
    step();
    chk("stall_pre_pc", o_pc, 32'h8);
    i_stall = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("stall_pc_c%0d", k), o_pc, 32'h8);
      chk($sformatf("stall_id_c%0d", k), o_id_instr, A1);
      chk($sformatf("stall_pc4_c%0d", k), o_id_pc_plus4, 32'h8);
    end
    i_stall = 1'b0;
    step();
    chk("stall_resume_pc", o_pc, 32'hC);
    chk("stall_resume_id", o_id_instr, A2);

    // Redirect at PC=0x10 to 0x40
    dut.memory[4] = ALT4;
    step();
    chk("br_pre_pc", o_pc, 32'h10);
    i_take_branch = 1'b1;
    i_branch_target = 32'h40;
    step();
    i_take_branch = 1'b0;
    chk("br_pc", o_pc, 32'h40);
    chk("br_valid", {31'd0, o_id_valid}, DS ? 32'd1 : 32'd0);
    chk("br_id_instr", o_id_instr, DS ? ALT4 : 32'h0);
    step();
    chk("br_next_pc", o_pc, 32'h44);
    chk("br_next_id", o_id_instr, filler(16));
    chk("br_next_pc4", o_id_pc_plus4, 32'h44);

    // Stall and redirect together: stall wins
    i_stall = 1'b1;
    i_take_branch = 1'b1;
    i_branch_target = 32'h80;
    step();
    chk("stbr_pc_hold", o_pc, 32'h44);
    chk("stbr_id_hold", o_id_instr, filler(16));
    i_stall = 1'b0;
    step();
    chk("stbr_pc", o_pc, 32'h80);
    chk("stbr_valid", {31'd0, o_id_valid}, DS ? 32'd1 : 32'd0);

    // Misaligned target
    i_branch_target = 32'h43;
    step();
    chk("mis_pc", o_pc, 32'h40);

    // Last word and out-of-range fetch
    i_branch_target = 32'h3FC;
    step();
    i_take_branch = 1'b0;
    chk("last_instr", o_instr, filler(255));
    step();
    chk("oor_pc", o_pc, 32'h400);
    chk("oor_instr", o_instr, 32'h0);
    chk("oor_id_last", o_id_instr, filler(255));
    step();
    chk("oor_id_nop", o_id_instr, 32'h0);
    chk("oor_id_valid", {31'd0, o_id_valid}, 32'd1);

    // HALT fetched alongside a redirect is squashed
    dut.memory[4] = HALT;
    i_take_branch = 1'b1;
    i_branch_target = 32'h10;
    step();
    chk("sq_instr_halt", o_instr, HALT);
    i_branch_target = 32'h20;
    step();
    i_take_branch = 1'b0;
    chk("sq_pc", o_pc, 32'h20);
    chk("sq_valid", {31'd0, o_id_valid}, 32'd0);
    step();
    chk("sq_running", o_pc, 32'h24);

    // Drain with stall, then reset in DRAIN
    i_take_branch = 1'b1;
    i_branch_target = 32'h10;
    step();
    i_take_branch = 1'b0;
    step();
    chk("dr_id_halt", o_id_instr, HALT);
    i_stall = 1'b1;
    step();
    step();
    i_stall = 1'b0;
    i_take_branch = 1'b1;
    i_branch_target = 32'h80;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("dr_stall_halt_c%0d", k), {31'd0, o_halt}, 32'd0);
      chk($sformatf("dr_pc_c%0d", k), o_pc, 32'h10);
    end
    i_take_branch = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_drain_pc", o_pc, 32'h0);
    chk("rst_drain_halt", {31'd0, o_halt}, 32'd0);
    chk("rst_drain_valid", {31'd0, o_id_valid}, 32'd0);
    step();
    chk("resume_pc", o_pc, 32'h4);
    chk("resume_id", o_id_instr, A0);
    chk("resume_valid", {31'd0, o_id_valid}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
